// File: rtl/blake_pkg.sv
// Shared widths, FSM state encoding and result record for the blake nonce scanner.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package blake_pkg;
    localparam int HDR_W     = 640;
    localparam int HASH_W    = 512;
    localparam int NONCE_W   = 32;
    localparam int NONCE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } result_t;
endpackage

// File: rtl/nonce_fifo.sv
// Synchronous show-ahead FIFO holding the nonces of headers still inside the core.
// Latency: push visible on pop_dat the cycle after the write; pop is same-cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/blake_nonce_scan.sv
// Job sequencer: streams one header per nonce into the blake core and reports hashes <= target.
// Latency: first core_ena 1 cycle after accept; hit_vld 2 cycles after the matching core_rdy.
// Backpressure: issue stalls while INFLIGHT headers are outstanding; job_rdy low while busy.
module blake_nonce_scan
    import blake_pkg::*;
#(
    parameter int INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               job_vld,
    output logic               job_rdy,
    input  logic [HDR_W-1:0]   job_hdr,
    input  logic [HASH_W-1:0]  job_target,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_cnt,
    input  logic               job_abort,
    output logic [HDR_W-1:0]   core_din,
    output logic               core_ena,
    input  logic               core_rdy,
    input  logic [HASH_W-1:0]  core_dout,
    output logic               hit_vld,
    output logic [NONCE_W-1:0] hit_nonce,
    output logic [HASH_W-1:0]  hit_hash,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err
);
    localparam int            CW       = $clog2(INFLIGHT + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(INFLIGHT);

    state_t                   state;
    state_t                   state_nxt;
    logic [HDR_W-1:NONCE_W]   hdr_q;
    logic [HASH_W-1:0]        target_q;
    logic [NONCE_W-1:0]       nonce_q;
    logic [NONCE_W-1:0]       remain_q;
    logic [CW-1:0]            credits;
    logic                     abort_seen;
    logic                     accept;
    logic                     issue;
    logic                     ret_vld;
    logic                     spur;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [NONCE_W-1:0]       fifo_dat;
    logic                     cap_vld;
    result_t                  cap_dat;
    result_t                  hit_dat;
    logic                     unused_hdr_lsb;

    // The template's nonce field is always replaced, so it is never stored.
    assign unused_hdr_lsb = ^job_hdr[NONCE_LSB +: NONCE_W];

    assign accept    = job_vld && job_rdy;
    assign ret_vld   = core_rdy && !fifo_empty;
    assign spur      = core_rdy && fifo_empty;
    assign core_din  = {hdr_q, nonce_q};
    assign core_ena  = issue;
    assign aborted   = done && abort_seen;
    assign hit_nonce = hit_dat.nonce;
    assign hit_hash  = hit_dat.hash;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        job_rdy   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                job_rdy = 1'b1;
                busy    = 1'b0;
                if (accept) state_nxt = (job_nonce_cnt == '0) ? DONE : RUN;
            end
            RUN: begin
                issue = (credits != '0) && (remain_q != '0) && !job_abort && !fifo_full;
                if (job_abort || (issue && remain_q == NONCE_W'(1))) state_nxt = DRAIN;
            end
            // Wait for every outstanding result and the last compare to retire.
            DRAIN: begin
                if (credits == CRED_MAX && !cap_vld) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hdr_q      <= '0;
            target_q   <= '0;
            nonce_q    <= '0;
            remain_q   <= '0;
            abort_seen <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                hdr_q      <= job_hdr[HDR_W-1:NONCE_W];
                target_q   <= job_target;
                nonce_q    <= job_nonce_start;
                remain_q   <= job_nonce_cnt;
                abort_seen <= 1'b0;
            end else if (issue) begin
                nonce_q  <= nonce_q + NONCE_W'(1);
                remain_q <= remain_q - NONCE_W'(1);
            end
            if ((state == RUN || state == DRAIN) && job_abort) abort_seen <= 1'b1;
            if (accept)    err <= 1'b0;
            else if (spur) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            credits <= CRED_MAX;
        end else begin
            case ({issue, ret_vld})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= (credits == CRED_MAX) ? CRED_MAX : credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Capture stage pairs the hash with its nonce; compare stage runs a cycle later.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cap_vld <= 1'b0;
            cap_dat <= '0;
            hit_vld <= 1'b0;
            hit_dat <= '0;
        end else begin
            cap_vld <= ret_vld;
            if (ret_vld) cap_dat <= '{nonce: fifo_dat, hash: core_dout};
            hit_vld <= cap_vld && (cap_dat.hash <= target_q);
            if (cap_vld && (cap_dat.hash <= target_q)) hit_dat <= cap_dat;
        end
    end

    nonce_fifo #(
        .WIDTH(NONCE_W),
        .DEPTH(INFLIGHT)
    ) u_nonce_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .push     (issue),
        .push_dat (nonce_q),
        .pop      (ret_vld),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );
endmodule
